// File: rtl/bt_tx_scheduler.sv
// Round-robin scheduler sharing one UART byte transmitter among four status-message requesters.
// Optional: define BT_TX_CHECKSUM_EN to append an XOR checksum byte after '#'.
module bt_tx_scheduler #(
  parameter int GAP_CYCLES = 434
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req_i,
  input  logic [15:0] arg0_i,
  input  logic [15:0] arg1_i,
  input  logic [15:0] arg2_i,
  input  logic [15:0] arg3_i,
  input  logic        tx_ready_i,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  output logic [3:0]  ack_o,
  output logic        busy_o,
  output logic [1:0]  grant_id_o
);

`ifdef BT_TX_CHECKSUM_EN
  localparam logic [3:0] LAST_IDX = 4'd8;
`else
  localparam logic [3:0] LAST_IDX = 4'd7;
`endif

  localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0]  GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [1:0]    rr_q, rr_d;
  logic [1:0]    grant_q, grant_d;
  logic [15:0]   arg_q, arg_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [3:0]    ack_q, ack_d;

  // Arbitration: lowest offset from rr_q wins, so scan offsets high to low.
  logic [1:0]  pick_id;
  logic [1:0]  cand;
  logic [15:0] pick_arg;
  always_comb begin
    pick_id = rr_q;
    cand    = rr_q;
    for (int k = 3; k >= 0; k--) begin
      cand = rr_q + 2'(k);
      if (req_i[cand]) pick_id = cand;
    end
  end

  always_comb begin
    case (pick_id)
      2'd0:    pick_arg = arg0_i;
      2'd1:    pick_arg = arg1_i;
      2'd2:    pick_arg = arg2_i;
      default: pick_arg = arg3_i;
    endcase
  end

  logic [23:0] pfx;
  always_comb begin
    case (grant_q)
      2'd0:    pfx = "FIM";
      2'd1:    pfx = "PBM";
      2'd2:    pfx = "DBM";
      default: pfx = "END";
    endcase
  end

  logic [7:0] byte_sel;
  always_comb begin
    case (idx_q)
      4'd0:    byte_sel = pfx[23:16];
      4'd1:    byte_sel = pfx[15:8];
      4'd2:    byte_sel = pfx[7:0];
      4'd3:    byte_sel = 8'h2D;
      4'd4:    byte_sel = arg_q[15:8];
      4'd5:    byte_sel = arg_q[7:0];
      4'd6:    byte_sel = 8'h2D;
      4'd7:    byte_sel = 8'h23;
`ifdef BT_TX_CHECKSUM_EN
      4'd8:    byte_sel = pfx[23:16] ^ pfx[15:8] ^ pfx[7:0] ^ 8'h2D ^
                          arg_q[15:8] ^ arg_q[7:0] ^ 8'h2D ^ 8'h23;
`endif
      default: byte_sel = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    arg_d   = arg_q;
    gap_d   = gap_q;
    ack_d   = 4'b0000;
    case (state_q)
      S_IDLE: begin
        if (|req_i) begin
          grant_d = pick_id;
          arg_d   = pick_arg;
          idx_d   = 4'd0;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (tx_ready_i) begin
          if (idx_q == LAST_IDX) begin
            ack_d   = 4'(4'b0001 << grant_q);
            rr_d    = grant_q + 2'd1;
            idx_d   = 4'd0;
            gap_d   = '0;
            state_d = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
          end else begin
            idx_d = idx_q + 4'd1;
          end
        end
      end
      S_GAP: begin
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      rr_q    <= 2'd0;
      grant_q <= 2'd0;
      arg_q   <= 16'h0000;
      gap_q   <= '0;
      ack_q   <= 4'b0000;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      arg_q   <= arg_d;
      gap_q   <= gap_d;
      ack_q   <= ack_d;
    end
  end

  assign tx_valid_o = (state_q == S_SEND);
  assign tx_data_o  = tx_valid_o ? byte_sel : 8'h00;
  assign busy_o     = (state_q != S_IDLE);
  assign ack_o      = ack_q;
  assign grant_id_o = grant_q;

endmodule

// File: tb/tb_bt_tx_scheduler.sv
// Scoreboard bench for bt_tx_scheduler: stimulus pushes expected bytes/acks, a negedge monitor checks them.
module tb_bt_tx_scheduler;
  localparam int GAP = 434;
`ifdef BT_TX_CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = 4'b0000;
  logic [15:0] arg0 = "EU", arg1 = "B2", arg2 = "C3", arg3 = "OK";
  logic        tx_ready = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [3:0]  ack;
  logic        busy;
  logic [1:0]  grant_id;

  bt_tx_scheduler #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .req_i(req),
    .arg0_i(arg0), .arg1_i(arg1), .arg2_i(arg2), .arg3_i(arg3),
    .tx_ready_i(tx_ready), .tx_data_o(tx_data), .tx_valid_o(tx_valid),
    .ack_o(ack), .busy_o(busy), .grant_id_o(grant_id)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int hs_cnt = 0;
  logic [7:0] exp_b[$];
  logic [3:0] exp_a[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_msg(input int id, input logic [15:0] a);
    logic [7:0]  m[8];
    logic [23:0] p;
    case (id)
      0:       p = "FIM";
      1:       p = "PBM";
      2:       p = "DBM";
      default: p = "END";
    endcase
    m[0] = p[23:16]; m[1] = p[15:8]; m[2] = p[7:0]; m[3] = "-";
    m[4] = a[15:8];  m[5] = a[7:0];  m[6] = "-";    m[7] = "#";
    for (int i = 0; i < 8; i++) exp_b.push_back(m[i]);
`ifdef BT_TX_CHECKSUM_EN
    begin
      logic [7:0] x;
      x = 8'h00;
      for (int i = 0; i < 8; i++) x = x ^ m[i];
      exp_b.push_back(x);
    end
`endif
    exp_a.push_back(4'(4'b0001 << id));
  endtask

  task automatic wait_ack(input int id, output int cyc);
    cyc = 0;
    while (!ack[id] && cyc < 700) begin
      tick();
      cyc++;
    end
    if (!ack[id]) begin
      total++; bad++;
      $display("FAIL ack_timeout: requester %0d got no ack", id);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < GAP + 50) begin
      tick();
      n++;
    end
    chk("idle_reached", busy, 0);
  endtask

  // Monitor: checks every accepted byte, stall stability and every ack pulse.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", {tx_valid, tx_data}, {1'b1, prev_data});
      if (tx_valid && tx_ready) begin
        if (exp_b.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_byte: got %0h expected none", tx_data);
        end else begin
          chk("byte", tx_data, exp_b.pop_front());
        end
        hs_cnt <= hs_cnt + 1;
      end
      if (ack != 4'b0000) begin
        chk("ack_onehot", 32'($onehot(ack)), 1);
        chk("ack_after_last", exp_b.size(), 0);
        if (exp_a.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_ack: got %0h expected none", ack);
        end else begin
          chk("ack", ack, exp_a.pop_front());
        end
      end
      prev_stall <= tx_valid && !tx_ready;
      prev_data  <= tx_data;
    end
  end

  initial begin
    int cyc;
    int n;
    int base;
    int order[5];
    order = '{0, 1, 2, 3, 0};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    rst_n = 1'b1;
    tick();

    // All four requesting: rotation 0,1,2,3,0 with each bit re-raised after its ack.
    push_msg(0, arg0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(order[k], cyc);
      chk("rr_grant_id", grant_id, order[k]);
      if (k == 4) req = 4'b0000;
      else req[order[k]] = 1'b0;
      tick();
      if (k < 4) begin
        req[order[k]] = 1'b1;
        case (order[k+1])
          0:       push_msg(0, arg0);
          1:       push_msg(1, arg1);
          2:       push_msg(2, arg2);
          default: push_msg(3, arg3);
        endcase
      end
    end
    wait_idle();

    // Back-pressure pattern 1,0,0,1 on requester 0.
    arg0 = "EU";
    push_msg(0, arg0);
    req = 4'b0001;
    n = 0;
    while (!ack[0] && n < 200) begin
      tick();
      tx_ready = ((n % 4) == 0) || ((n % 4) == 3);
      n++;
    end
    chk("stall_ack_seen", ack[0], 1);
    req = 4'b0000;
    tx_ready = 1'b1;
    wait_idle();

    // Requester 3 drops its request and changes args mid-message.
    arg3 = "OK";
    push_msg(3, arg3);
    req = 4'b1000;
    tick();
    tick();
    tick();
    req = 4'b0000;
    arg3 = "ZZ";
    wait_ack(3, cyc);
    wait_idle();

    // Reset after three accepted bytes aborts the message with no ack.
    push_msg(2, arg2);
    req = 4'b0100;
    base = hs_cnt;
    n = 0;
    while (hs_cnt < base + 3 && n < 50) begin
      tick();
      n++;
    end
    chk("abort_three_bytes", hs_cnt - base, 3);
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_tx_data", tx_data, 0);
    chk("abort_ack", ack, 0);
    chk("abort_busy", busy, 0);
    chk("abort_grant_id", grant_id, 0);
    exp_b.delete();
    exp_a.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Requester 1 after reset: full message, 1-cycle grant latency, then GAP clocks busy.
    push_msg(1, arg1);
    req = 4'b0010;
    tick();
    chk("grant_tx_valid", tx_valid, 1);
    chk("grant_byte0", tx_data, "P");
    chk("grant_busy", busy, 1);
    chk("grant_id_1", grant_id, 1);
    wait_ack(1, cyc);
    chk("ack_latency", cyc, NB);
    chk("ack_tx_valid_low", tx_valid, 0);
    req = 4'b0000;
    n = 0;
    while (busy && n < GAP + 20) begin
      n++;
      tick();
    end
    chk("gap_busy_cycles", n, GAP);
    tick();

    chk("sb_bytes_empty", exp_b.size(), 0);
    chk("sb_acks_empty", exp_a.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/bt_tx_scheduler.md
# bt_tx_scheduler

Round-robin scheduler that shares the single HC-05 UART transmit byte engine among four message requesters in the bot CPU. Each requester asks for one fixed-format 8-byte ASCII status message of the form `PPP-AA-#`. The scheduler grants one requester, serialises its bytes to the transmitter over a valid/ready handshake, acknowledges completion, and enforces an inter-message gap. It is the transmit-side counterpart of the command receiver/decoder on the same link.

## Interface
- GAP_CYCLES, 434: idle clocks between the end of one message and the next grant (434 = one bit time at 115200 baud from 50 MHz); 0 allowed.
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  4  request level, one bit per requester; held until its ack.
- arg0, arg1, arg2, arg3  input  16 each  two ASCII argument chars for requester i, [15:8] sent first; sampled at grant.
- tx_ready  input  1  transmitter can accept a byte this cycle.
- tx_data  output  8  byte to transmit.
- tx_valid  output  1  tx_data valid; transfer on tx_valid && tx_ready.
- ack  output  4  one-cycle pulse on bit i when requester i's message has been fully accepted.
- busy  output  1  high in SEND and GAP.
- grant_id  output  2  index of the current/last granted requester.

## Operation
- Fixed prefixes: req0 "FIM", req1 "PBM", req2 "DBM", req3 "END".
- Byte sequence: P0 P1 P2 '-' arg[15:8] arg[7:0] '-' '#' (indices 0..7).
- States:
  - IDLE: if req != 0, pick the first set bit scanning rr_ptr, rr_ptr+1, ... mod 4. Latch that arg and grant_id, set idx=0, go to SEND.
  - SEND: drive byte[idx] with tx_valid=1. On each handshake idx++. On the handshake of the last byte, go to GAP (or to IDLE if GAP_CYCLES==0) and set rr_ptr = grant_id+1 mod 4.
  - GAP: count GAP_CYCLES clocks, then go to IDLE.
- tx_data and tx_valid hold stable while tx_valid && !tx_ready. Arguments are never re-sampled mid-message.
- A req that drops after grant does not abort: the message completes and ack still pulses.
- A req still high in IDLE after its ack is treated as a new request; round-robin gives the other requesters priority first.
- Reset values: tx_valid 0, tx_data 0x00, ack 0, busy 0, grant_id 0, rr_ptr 0, state IDLE, idx 0, gap counter 0.
- rst_n asserted mid-message aborts immediately. No ack is issued, and the partially sent message is not resumed.

## Timing
- req sampled high in IDLE at edge N: tx_valid=1 with byte 0 and busy=1 after edge N. This is a 1-cycle grant latency.
- With tx_ready held at 1: one byte per cycle, 8 cycles in SEND.
- Last handshake at edge M:
  - ack[g]=1 and tx_valid=0 for the cycle after edge M only.
  - GAP occupies edges M+1 .. M+GAP_CYCLES.
  - The next grant can occur at edge M+GAP_CYCLES+1.
- busy falls on entry to IDLE.
- With GAP_CYCLES==0: state is IDLE after edge M, and the next grant can occur at edge M+1. This gives 1 idle cycle between messages, coinciding with ack.
- Simultaneous requests are resolved purely by rr_ptr. Requests arriving during SEND/GAP wait, with no loss.
- ack is never asserted for more than one requester at a time.

## Configuration
- BT_TX_CHECKSUM_EN defined:
  - A 9th byte is sent after '#': the XOR of bytes 0..7.
  - SEND runs for indices 0..8, and ack follows the 9th handshake.
- BT_TX_CHECKSUM_EN undefined: exactly 8 bytes; no checksum logic.

## Test plan
- Reset mid-SEND (after 3 bytes) -> all outputs at reset values, no ack, next req1 sends a full message from byte 0.
- req=0010, arg1="B2", tx_ready=1, GAP_CYCLES=434 -> tx_data "PBM-B2-#" on 8 consecutive cycles, starting 1 cycle after req. ack=0010 for one cycle, then busy stays high for 434 more cycles.
- req=1111 held and re-raised after each ack -> grants in order 0,1,2,3,0. grant_id and prefixes match each grant, and no ack overlaps another.
- tx_ready toggling 1,0,0,1,... during req0 ("FIM-EU-#") -> tx_data stable while stalled, no byte duplicated or skipped, ack after the 8th accepted byte.
- req3 dropped 2 cycles after grant, arg3 changed mid-message -> "END" plus the originally latched args completes, and ack[3] pulses.
- BT_TX_CHECKSUM_EN, req0, arg0="EU" -> 9 bytes. The 9th byte equals the XOR of "FIM-EU-#", and ack follows it.
